// File: rtl/spi_apb_bridge_pkg.sv
// Shared definitions for the SPI-slave to APB-master bridge.
//   state_e       : bridge FSM state encoding
//   CMD_*         : field positions inside the command byte {W, A[6:0]}
//   STATUS_*      : bit positions inside the status byte shifted out during byte0
//   status_byte() : assembles the status byte from the last-access flags
package spi_apb_bridge_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StCmd,
        StWdata,
        StSetup,
        StAccess,
        StRdata,
        StDrain
    } state_e;

    localparam int unsigned CMD_W_BIT    = 7;
    localparam int unsigned CMD_ADDR_MSB = 6;

    localparam int unsigned STATUS_UNDERRUN_BIT = 0;
    localparam int unsigned STATUS_PSLVERR_BIT  = 1;

    function automatic logic [7:0] status_byte(input logic pslverr, input logic underrun);
        logic [7:0] s;
        s                      = '0;
        s[STATUS_PSLVERR_BIT]  = pslverr;
        s[STATUS_UNDERRUN_BIT] = underrun;
        return s;
    endfunction

endpackage

// File: rtl/spi_apb_bridge_if.sv
// Pin bundle of the bridge: board-side SPI pins, APB initiator signals and status flags.
//   master : bridge view (drives SPISDO/SPIOEN, the APB request signals, BUSY, ERR)
//   slave  : environment view (drives SPI pins from the external master, APB responses)
interface spi_apb_bridge_if #(
    parameter int unsigned APB_DWIDTH = 8
);
    logic                  SPISCLK;
    logic                  SPISS;
    logic                  SPISDI;
    logic                  SPISDO;
    logic                  SPIOEN;
    logic [6:0]            PADDR;
    logic                  PSEL;
    logic                  PENABLE;
    logic                  PWRITE;
    logic [APB_DWIDTH-1:0] PWDATA;
    logic [APB_DWIDTH-1:0] PRDATA;
    logic                  PREADY;
    logic                  PSLVERR;
    logic                  BUSY;
    logic                  ERR;

    modport master (
        input  SPISCLK, SPISS, SPISDI, PRDATA, PREADY, PSLVERR,
        output SPISDO, SPIOEN, PADDR, PSEL, PENABLE, PWRITE, PWDATA, BUSY, ERR
    );

    modport slave (
        output SPISCLK, SPISS, SPISDI, PRDATA, PREADY, PSLVERR,
        input  SPISDO, SPIOEN, PADDR, PSEL, PENABLE, PWRITE, PWDATA, BUSY, ERR
    );

endinterface

// File: rtl/spi_apb_bridge_sync.sv
// Brings the asynchronous SPI pins into the PCLK domain and detects SCLK/SS edges.
//   clk_i, rst_i  : PCLK and synchronous active-high reset
//   sclk_i/ss_i/sdi_i : raw SPI pins
//   sclk_rise_o/sclk_fall_o : one-cycle pulses on synchronized SCLK edges
//   ss_fall_o/ss_rise_o     : one-cycle pulses on synchronized SS edges
//   ss_o, sdi_o             : synchronized levels, aligned with the edge pulses
module spi_apb_bridge_sync #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic sclk_i,
    input  logic ss_i,
    input  logic sdi_i,
    output logic sclk_rise_o,
    output logic sclk_fall_o,
    output logic ss_fall_o,
    output logic ss_rise_o,
    output logic ss_o,
    output logic sdi_o
);

    logic [SYNC_STAGES-1:0] sclk_sync;
    logic [SYNC_STAGES-1:0] ss_sync;
    logic [SYNC_STAGES-1:0] sdi_sync;
    logic                   sclk_prev;
    logic                   ss_prev;

    // SS resets to the deselected level so reset release never fakes a frame start.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sclk_sync <= '0;
            ss_sync   <= '1;
            sdi_sync  <= '0;
            sclk_prev <= 1'b0;
            ss_prev   <= 1'b1;
        end else begin
            sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], sclk_i};
            ss_sync   <= {ss_sync[SYNC_STAGES-2:0], ss_i};
            sdi_sync  <= {sdi_sync[SYNC_STAGES-2:0], sdi_i};
            sclk_prev <= sclk_sync[SYNC_STAGES-1];
            ss_prev   <= ss_sync[SYNC_STAGES-1];
        end
    end

    assign sclk_rise_o = sclk_sync[SYNC_STAGES-1] & ~sclk_prev;
    assign sclk_fall_o = ~sclk_sync[SYNC_STAGES-1] & sclk_prev;
    assign ss_fall_o   = ~ss_sync[SYNC_STAGES-1] & ss_prev;
    assign ss_rise_o   = ss_sync[SYNC_STAGES-1] & ~ss_prev;
    assign ss_o        = ss_sync[SYNC_STAGES-1];
    // SDI comes off the same stage depth as SCLK, so it is stable when a rise is flagged.
    assign sdi_o       = sdi_sync[SYNC_STAGES-1];

endmodule

// File: rtl/spi_apb_bridge.sv
// SPI-slave (mode 0) to APB-master bridge. Each SS frame carries one command byte {W, A[6:0]}
// followed by APB_DWIDTH/8 data bytes (written in, or read data shifted out MSB first), and
// produces exactly one APB access. All SPI pins are oversampled in PCLK.
//   PCLK, PRESET : sole clock, synchronous active-high reset
//   bus (master) : SPISCLK/SPISS/SPISDI in, SPISDO/SPIOEN out; APB PADDR/PSEL/PENABLE/PWRITE/
//                  PWDATA out, PRDATA/PREADY/PSLVERR in; BUSY (frame in progress), ERR (sticky)
module spi_apb_bridge
    import spi_apb_bridge_pkg::*;
#(
    parameter int unsigned APB_DWIDTH  = 8,
    parameter int unsigned SYNC_STAGES = 2
) (
    input logic              PCLK,
    input logic              PRESET,
    spi_apb_bridge_if.master bus
);

    localparam int unsigned FRAME_BITS = 8 + APB_DWIDTH;
    localparam int unsigned CNT_W      = $clog2(FRAME_BITS + 1);

    localparam logic [CNT_W-1:0] CMD_LAST   = CNT_W'(7);
    localparam logic [CNT_W-1:0] DATA_FIRST = CNT_W'(8);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_END  = CNT_W'(FRAME_BITS);

    logic sclk_rise, sclk_fall, ss_fall, ss_rise, ss_level, sdi;

    spi_apb_bridge_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk_i       (PCLK),
        .rst_i       (PRESET),
        .sclk_i      (bus.SPISCLK),
        .ss_i        (bus.SPISS),
        .sdi_i       (bus.SPISDI),
        .sclk_rise_o (sclk_rise),
        .sclk_fall_o (sclk_fall),
        .ss_fall_o   (ss_fall),
        .ss_rise_o   (ss_rise),
        .ss_o        (ss_level),
        .sdi_o       (sdi)
    );

    state_e                  state;
    logic [CNT_W-1:0]        bit_cnt;      // SCLK rises seen in this frame, saturating
    logic [6:0]              cmd_sr;       // holds A[6:0] once the command byte is complete
    logic [APB_DWIDTH-1:0]   wdata_sr;
    logic [7:0]              stat_sr;
    logic [APB_DWIDTH-1:0]   rdata_sr;
    logic                    frame_write;
    logic                    rdata_valid;
    logic                    underrun;
    logic                    last_pslverr;
    logic                    last_underrun;
    logic                    err;
    logic                    busy;
    logic                    spioen;
    logic                    sdo;
    logic                    psel;
    logic                    penable;
    logic                    pwrite;
    logic [6:0]              paddr;
    logic [APB_DWIDTH-1:0]   pwdata;

    logic [7:0] status;
    logic [7:0] cmd_byte;
    logic       access_done;
    logic       data_fall;
    logic       underrun_now;

    assign status      = status_byte(last_pslverr, last_underrun);
    assign cmd_byte    = {cmd_sr, sdi};
    assign access_done = (state == StAccess) && bus.PREADY;
    assign data_fall   = (state != StIdle) && sclk_fall &&
                         (bit_cnt >= DATA_FIRST) && (bit_cnt < FRAME_END);
    // First read-data bit is due but PRDATA has not been captured yet.
    assign underrun_now = data_fall && (bit_cnt == DATA_FIRST) && !frame_write && !rdata_valid;

    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            state         <= StIdle;
            bit_cnt       <= '0;
            cmd_sr        <= '0;
            wdata_sr      <= '0;
            stat_sr       <= '0;
            rdata_sr      <= '0;
            frame_write   <= 1'b0;
            rdata_valid   <= 1'b0;
            underrun      <= 1'b0;
            last_pslverr  <= 1'b0;
            last_underrun <= 1'b0;
            err           <= 1'b0;
            busy          <= 1'b0;
            spioen        <= 1'b0;
            sdo           <= 1'b0;
            psel          <= 1'b0;
            penable       <= 1'b0;
            pwrite        <= 1'b0;
            paddr         <= '0;
            pwdata        <= '0;
        end else begin
            // Rises keep counting after the command so SDO knows where it is in the frame.
            if ((state != StIdle) && sclk_rise && (bit_cnt != FRAME_END)) begin
                bit_cnt <= bit_cnt + CNT_W'(1);
            end

            // Serial output, updated on SCLK falls.
            if (ss_rise) begin
                spioen <= 1'b0;
                sdo    <= 1'b0;
            end else if ((state != StIdle) && sclk_fall) begin
                if ((bit_cnt != '0) && (bit_cnt < DATA_FIRST)) begin
                    sdo     <= stat_sr[7];
                    stat_sr <= stat_sr << 1;
                end else if (data_fall) begin
                    if (frame_write) begin
                        sdo <= 1'b0;
                    end else if (underrun || underrun_now) begin
                        sdo <= 1'b1;
                    end else begin
                        sdo      <= rdata_sr[APB_DWIDTH-1];
                        rdata_sr <= rdata_sr << 1;
                    end
                end else if (bit_cnt >= FRAME_END) begin
                    sdo <= 1'b0;
                end
            end

            if (underrun_now) begin
                underrun <= 1'b1;
            end
            err <= err | underrun_now | (access_done & bus.PSLVERR);
            if (access_done) begin
                last_pslverr  <= bus.PSLVERR;
                last_underrun <= underrun | underrun_now;
            end else if (underrun_now) begin
                last_underrun <= 1'b1;
            end

            unique case (state)
                StIdle: begin
                    if (ss_fall) begin
                        state       <= StCmd;
                        busy        <= 1'b1;
                        spioen      <= 1'b1;
                        sdo         <= status[7];
                        stat_sr     <= status << 1;
                        bit_cnt     <= '0;
                        frame_write <= 1'b0;
                        rdata_valid <= 1'b0;
                        underrun    <= 1'b0;
                    end
                end
                StCmd: begin
                    if (ss_level) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (sclk_rise) begin
                        cmd_sr <= cmd_byte[6:0];
                        if (bit_cnt == CMD_LAST) begin
                            frame_write <= cmd_byte[CMD_W_BIT];
                            if (cmd_byte[CMD_W_BIT]) begin
                                state <= StWdata;
                            end else begin
                                state  <= StSetup;
                                paddr  <= cmd_byte[CMD_ADDR_MSB:0];
                                pwrite <= 1'b0;
                                psel   <= 1'b1;
                            end
                        end
                    end
                end
                StWdata: begin
                    // Abort drops the partial word; nothing reaches the APB side.
                    if (ss_level) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (sclk_rise) begin
                        wdata_sr <= {wdata_sr[APB_DWIDTH-2:0], sdi};
                        if (bit_cnt == FRAME_LAST) begin
                            state  <= StSetup;
                            pwdata <= {wdata_sr[APB_DWIDTH-2:0], sdi};
                            paddr  <= cmd_sr;
                            pwrite <= 1'b1;
                            psel   <= 1'b1;
                        end
                    end
                end
                StSetup: begin
                    penable <= 1'b1;
                    state   <= StAccess;
                end
                StAccess: begin
                    // Once started, the APB access always finishes regardless of SS.
                    if (bus.PREADY) begin
                        psel    <= 1'b0;
                        penable <= 1'b0;
                        if (frame_write) begin
                            state <= StDrain;
                        end else begin
                            rdata_sr    <= bus.PRDATA;
                            rdata_valid <= 1'b1;
                            state       <= StRdata;
                        end
                    end
                end
                StRdata: begin
                    if (ss_level) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end else if (bit_cnt >= FRAME_END) begin
                        state <= StDrain;
                    end
                end
                StDrain: begin
                    if (ss_level) begin
                        state <= StIdle;
                        busy  <= 1'b0;
                    end
                end
                default: begin
                    state <= StIdle;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.SPISDO  = sdo;
    assign bus.SPIOEN  = spioen;
    assign bus.PADDR   = paddr;
    assign bus.PSEL    = psel;
    assign bus.PENABLE = penable;
    assign bus.PWRITE  = pwrite;
    assign bus.PWDATA  = pwdata;
    assign bus.BUSY    = busy;
    assign bus.ERR     = err;

endmodule

// File: tb/tb_spi_apb_bridge.sv
module tb_spi_apb_bridge;
    import spi_apb_bridge_pkg::*;

    logic       PCLK = 1'b0;
    logic       PRESET;
    logic       sclk, sdi, ss8, ss32;
    logic [7:0] prdata8;
    logic       pslverr_en;
    int         ready_delay;
    int         acc_cnt = 0;

    int checks = 0;
    int errors = 0;

    // APB monitor counters for the 8-bit instance
    int         psel_cyc = 0, pen_cyc = 0, xfers = 0, unstable = 0;
    logic [6:0] setup_addr;
    logic [7:0] setup_wdata;
    logic       setup_write;

    always #5 PCLK = ~PCLK;

    spi_apb_bridge_if #(.APB_DWIDTH(8))  if8 ();
    spi_apb_bridge_if #(.APB_DWIDTH(32)) if32 ();

    spi_apb_bridge #(.APB_DWIDTH(8), .SYNC_STAGES(2)) dut8 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (if8.master)
    );

    spi_apb_bridge #(.APB_DWIDTH(32), .SYNC_STAGES(2)) dut32 (
        .PCLK   (PCLK),
        .PRESET (PRESET),
        .bus    (if32.master)
    );

    assign if8.SPISCLK  = sclk;
    assign if8.SPISDI   = sdi;
    assign if8.SPISS    = ss8;
    assign if8.PRDATA   = prdata8;
    assign if8.PREADY   = if8.PSEL & if8.PENABLE & (acc_cnt >= ready_delay);
    assign if8.PSLVERR  = pslverr_en & if8.PREADY;

    assign if32.SPISCLK = sclk;
    assign if32.SPISDI  = sdi;
    assign if32.SPISS   = ss32;
    assign if32.PRDATA  = 32'hDEADBEEF;
    assign if32.PREADY  = 1'b1;
    assign if32.PSLVERR = 1'b0;

    always @(posedge PCLK) begin
        if (if8.PSEL && if8.PENABLE && !if8.PREADY) acc_cnt <= acc_cnt + 1;
        else acc_cnt <= 0;
        if (if8.PSEL) psel_cyc <= psel_cyc + 1;
        if (if8.PSEL && !if8.PENABLE) begin
            setup_addr  <= if8.PADDR;
            setup_wdata <= if8.PWDATA;
            setup_write <= if8.PWRITE;
        end
        if (if8.PSEL && if8.PENABLE) begin
            pen_cyc <= pen_cyc + 1;
            if (if8.PADDR !== setup_addr || if8.PWDATA !== setup_wdata ||
                if8.PWRITE !== setup_write) unstable <= unstable + 1;
            if (if8.PREADY) xfers <= xfers + 1;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Mode 0 master: SDI set while SCLK low, SDO sampled as SCLK rises; SCLK = 8 PCLK.
    task automatic spi_bits(input logic [39:0] tx, input int n, input bit sel32,
                            output logic [39:0] rx);
        rx = '0;
        for (int i = n - 1; i >= 0; i--) begin
            sdi = tx[i];
            repeat (4) @(negedge PCLK);
            rx   = {rx[38:0], (sel32 ? if32.SPISDO : if8.SPISDO)};
            sclk = 1'b1;
            repeat (4) @(negedge PCLK);
            sclk = 1'b0;
        end
    endtask

    task automatic frame(input logic [39:0] tx, input int n, input bit sel32,
                         output logic [39:0] rx);
        if (sel32) ss32 = 1'b0;
        else ss8 = 1'b0;
        repeat (4) @(negedge PCLK);
        spi_bits(tx, n, sel32, rx);
        repeat (4) @(negedge PCLK);
        ss8  = 1'b1;
        ss32 = 1'b1;
        sdi  = 1'b0;
        repeat (30) @(negedge PCLK);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [39:0] rx;
        int          p0, e0, x0;

        PRESET      = 1'b1;
        sclk        = 1'b0;
        sdi         = 1'b0;
        ss8         = 1'b1;
        ss32        = 1'b1;
        prdata8     = 8'h00;
        pslverr_en  = 1'b0;
        ready_delay = 0;
        repeat (4) @(negedge PCLK);

        // Reset state
        check("rst_sdo",     if8.SPISDO,  1'b0);
        check("rst_oen",     if8.SPIOEN,  1'b0);
        check("rst_psel",    {if8.PSEL, if8.PENABLE, if8.PWRITE}, 3'b000);
        check("rst_paddr",   if8.PADDR,   7'h00);
        check("rst_pwdata",  if8.PWDATA,  8'h00);
        check("rst_busyerr", {if8.BUSY, if8.ERR}, 2'b00);
        PRESET = 1'b0;
        repeat (4) @(negedge PCLK);

        // Plain write 0x85,0x3C
        p0 = psel_cyc; e0 = pen_cyc; x0 = xfers;
        frame(40'h853C, 16, 1'b0, rx);
        check("wr_sdo",    rx[15:0],        16'h0000);
        check("wr_xfers",  xfers - x0,      1);
        check("wr_psel",   psel_cyc - p0,   2);
        check("wr_pen",    pen_cyc - e0,    1);
        check("wr_paddr",  if8.PADDR,       7'h05);
        check("wr_pwdata", if8.PWDATA,      8'h3C);
        check("wr_pwrite", if8.PWRITE,      1'b1);
        check("wr_idle",   {if8.BUSY, if8.SPIOEN, if8.ERR}, 3'b000);

        // Read 0x12 returning 0xA7
        prdata8 = 8'hA7;
        frame(40'h1200, 16, 1'b0, rx);
        check("rd_sdo",    rx[15:0],   16'h00A7);
        check("rd_paddr",  if8.PADDR,  7'h12);
        check("rd_pwrite", if8.PWRITE, 1'b0);
        check("rd_hold",   if8.PWDATA, 8'h3C);
        check("rd_err",    if8.ERR,    1'b0);

        // Write with 3 wait states
        ready_delay = 3;
        p0 = psel_cyc; e0 = pen_cyc;
        frame(40'h9A5A, 16, 1'b0, rx);
        ready_delay = 0;
        check("ws_pen",    pen_cyc - e0,  4);
        check("ws_psel",   psel_cyc - p0, 5);
        check("ws_stable", unstable,      0);
        check("ws_paddr",  if8.PADDR,     7'h1A);
        check("ws_pwdata", if8.PWDATA,    8'h5A);

        // Abort after 4 data bits, then clean write
        p0 = psel_cyc; x0 = xfers;
        frame(40'h83F, 12, 1'b0, rx);
        check("ab_psel",  psel_cyc - p0, 0);
        check("ab_busy",  if8.BUSY,      1'b0);
        frame(40'h8155, 16, 1'b0, rx);
        check("ab_xfers", xfers - x0,    1);
        check("ab_paddr", if8.PADDR,     7'h01);
        check("ab_wdata", if8.PWDATA,    8'h55);

        // PSLVERR on a write
        pslverr_en = 1'b1;
        frame(40'h8411, 16, 1'b0, rx);
        pslverr_en = 1'b0;
        check("se_err",   if8.ERR,   1'b1);
        check("se_paddr", if8.PADDR, 7'h04);

        // Read underrun; status byte reports the earlier PSLVERR
        ready_delay = 20;
        prdata8     = 8'h3C;
        frame(40'h1200, 16, 1'b0, rx);
        ready_delay = 0;
        check("ur_sdo", rx[15:0], 16'h02FF);
        check("ur_err", if8.ERR,  1'b1);

        frame(40'h8100, 16, 1'b0, rx);
        check("ur_status", rx[15:0], 16'h0100);

        // 32-bit instance read
        frame(40'h12_0000_0000, 40, 1'b1, rx);
        check("w32_sdo",   rx,         40'h00DEADBEEF);
        check("w32_paddr", if32.PADDR, 7'h12);

        // Reset during ACCESS
        ready_delay = 200;
        ss8 = 1'b0;
        repeat (4) @(negedge PCLK);
        spi_bits(40'h05, 8, 1'b0, rx);
        for (int i = 0; i < 40 && !(if8.PSEL && if8.PENABLE); i++) @(negedge PCLK);
        check("pr_access", {if8.PSEL, if8.PENABLE}, 2'b11);
        check("pr_errpre", if8.ERR, 1'b1);
        @(negedge PCLK);
        PRESET = 1'b1;
        @(posedge PCLK);
        #1;
        check("pr_apb",  {if8.PSEL, if8.PENABLE}, 2'b00);
        check("pr_busy", {if8.BUSY, if8.ERR},     2'b00);
        ss8 = 1'b1;
        repeat (4) @(negedge PCLK);
        PRESET = 1'b0;
        repeat (10) @(negedge PCLK);
        ready_delay = 0;
        check("pr_idle",  {if8.BUSY, if8.SPIOEN, if8.PSEL}, 3'b000);
        check("pr_state", 64'(dut8.state), 64'(StIdle));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
